// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and address-decode constants for the two-requester APB master
// and for bus-level benches.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned SLAVE_SEL_BIT = 8;
  localparam logic        GPIO_SEL      = 1'b0;
  localparam logic        UART_SEL      = 1'b1;

  // Any address bit at or above bit 9 set means no slave is mapped there.
  localparam logic [63:0] DEC_ERR_MASK  = 64'hFFFF_FFFF_FFFF_FE00;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester handshake and shared APB bus of apb_master_arbiter; the master
// modport is the arbiter side, the slave modport is the requesters/slaves side.
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [7:0]          req_strb;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [3:0]          PSTRB;
  logic                PWRITE;
  logic                PENABLE;
  logic                PSEL_GPIO;
  logic                PSEL_UART;
  logic [DATA_W-1:0]   PRDATA_GPIO;
  logic [DATA_W-1:0]   PRDATA_UART;
  logic                PREADY_GPIO;
  logic                PREADY_UART;
  logic                PSLVERR_GPIO;
  logic                PSLVERR_UART;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PSTRB, PWRITE, PENABLE, PSEL_GPIO, PSEL_UART,
    input  PRDATA_GPIO, PRDATA_UART, PREADY_GPIO, PREADY_UART,
    input  PSLVERR_GPIO, PSLVERR_UART
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWDATA, PSTRB, PWRITE, PENABLE, PSEL_GPIO, PSEL_UART,
    output PRDATA_GPIO, PRDATA_UART, PREADY_GPIO, PREADY_UART,
    output PSLVERR_GPIO, PSLVERR_UART
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer resets to requester 1 so
// requester 0 wins the first contention.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = req;
    if (&req) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (accept) last <= grant[1];
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master driving the GPIO/UART slave bus.
// Optional ACCESS wait timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_arbiter_if.master bus
);

  apb_state_e        state, state_nxt;
  logic [1:0]        grant;
  logic              accept;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [3:0]        win_strb;
  logic              win_write;
  logic              dec_err;
  logic              owner;
  logic              sel;
  logic              pready_sel;
  logic              pslverr_sel;
  logic [DATA_W-1:0] prdata_sel;
  logic              done;
  logic              abort;

  assign accept = (state == IDLE) && (|bus.req_valid);

  rr_arbiter2 u_arb (
    .clk    (PCLK),
    .rst    (PRESET),
    .req    (bus.req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.req_ready = (state == IDLE && !PRESET) ? grant : '0;

  assign win       = grant[1];
  assign win_addr  = win ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
  assign win_wdata = win ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  assign win_strb  = win ? bus.req_strb[7:4] : bus.req_strb[3:0];
  assign win_write = win ? bus.req_write[1] : bus.req_write[0];
  assign dec_err   = |(win_addr & DEC_ERR_MASK[ADDR_W-1:0]);

  assign pready_sel  = (sel == UART_SEL) ? bus.PREADY_UART  : bus.PREADY_GPIO;
  assign pslverr_sel = (sel == UART_SEL) ? bus.PSLVERR_UART : bus.PSLVERR_GPIO;
  assign prdata_sel  = (sel == UART_SEL) ? bus.PRDATA_UART  : bus.PRDATA_GPIO;
  assign done        = (state == ACCESS) && pready_sel;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Abort on the edge where the low-PREADY count would reach TIMEOUT.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                wait_cnt <= '0;
    else if (state == SETUP)                   wait_cnt <= '0;
    else if (state == ACCESS && !pready_sel)   wait_cnt <= wait_cnt + 1'b1;
  end

  assign abort = (state == ACCESS) && !pready_sel &&
                 (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !dec_err) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.PSEL_GPIO = 1'b0;
    bus.PSEL_UART = 1'b0;
    bus.PENABLE   = 1'b0;
    if (state != IDLE) begin
      bus.PSEL_GPIO = (sel == GPIO_SEL);
      bus.PSEL_UART = (sel == UART_SEL);
      bus.PENABLE   = (state == ACCESS);
    end
  end

  // Transfer fields are captured at acceptance and held until the next one.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bus.PADDR  <= '0;
      bus.PWDATA <= '0;
      bus.PSTRB  <= '0;
      bus.PWRITE <= 1'b0;
      owner      <= 1'b0;
      sel        <= 1'b0;
    end else if (accept) begin
      bus.PADDR  <= win_addr;
      bus.PWDATA <= win_wdata;
      bus.PSTRB  <= win_write ? win_strb : '0;
      bus.PWRITE <= win_write;
      owner      <= win;
      sel        <= win_addr[SLAVE_SEL_BIT];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      if (accept && dec_err) begin
        bus.rsp_valid <= win ? 2'b10 : 2'b01;
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= 1'b1;
      end else if (done || abort) begin
        bus.rsp_valid <= owner ? 2'b10 : 2'b01;
        bus.rsp_rdata <= (abort || bus.PWRITE) ? '0 : prdata_sel;
        bus.rsp_err   <= abort ? 1'b1 : pslverr_sel;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: transaction-timeline model plus
// directed vectors; timeout scenario follows APB_TIMEOUT_EN.
module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;

  apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave responder configuration (written only by the stimulus process).
  int          wait_g = 0, wait_u = 0;
  logic [31:0] rd_g = 32'hC0DE_0001, rd_u = 32'h0000_005A;
  logic        err_g = 1'b0, err_u = 1'b0;
  int          cnt_g = 0, cnt_u = 0;

  always @(negedge PCLK) begin
    if (bus.PSEL_GPIO && bus.PENABLE) cnt_g++; else cnt_g = 0;
    if (bus.PSEL_UART && bus.PENABLE) cnt_u++; else cnt_u = 0;
    bus.PREADY_GPIO  = (cnt_g > wait_g);
    bus.PREADY_UART  = (cnt_u > wait_u);
    bus.PRDATA_GPIO  = rd_g;
    bus.PRDATA_UART  = rd_u;
    bus.PSLVERR_GPIO = err_g;
    bus.PSLVERR_UART = err_u;
  end

  // Model: one transaction timeline. Accept at edge k, PSEL over periods
  // k..k+n_acc, PENABLE over k+1..k+n_acc, response in period rsp_edge.
  int          ecount = 0;
  int          next_free = 0;
  bit          last = 1'b1;
  bit          busy = 1'b0;
  int          k = 0, n_acc = 0, rsp_edge = -1;
  bit          rsp_own = 1'b0;
  logic [31:0] rsp_rd = '0;
  bit          rsp_er = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_strb = '0;
  bit          m_write = 1'b0, m_uart = 1'b0;
  bit          wi, tmo;
  int          w;

  function automatic bit pick(input logic [1:0] v, input bit l);
    if (v == 2'b11) return (l == 1'b1) ? 1'b0 : 1'b1;
    return v[1];
  endfunction

  always @(posedge PCLK) begin
    ecount++;
    if (PRESET) begin
      busy = 0; next_free = 0; last = 1'b1; rsp_edge = -1;
    end else if (ecount >= next_free && bus.req_valid != 2'b00) begin
      wi      = pick(bus.req_valid, last);
      last    = wi;
      m_addr  = bus.req_addr[wi*32 +: 32];
      m_wdata = bus.req_wdata[wi*32 +: 32];
      m_strb  = bus.req_strb[wi*4 +: 4];
      m_write = bus.req_write[wi];
      rsp_own = wi;
      if (m_addr >= 32'h200) begin
        busy = 0; rsp_edge = ecount; rsp_er = 1'b1; rsp_rd = '0; next_free = ecount + 1;
      end else begin
        m_uart = (m_addr >= 32'h100);
        w   = m_uart ? wait_u : wait_g;
        tmo = 1'b0;
        n_acc = w + 1;
`ifdef APB_TIMEOUT_EN
        if (w >= TO) begin n_acc = TO; tmo = 1'b1; end
`endif
        busy = 1; k = ecount; rsp_edge = k + 1 + n_acc; next_free = rsp_edge + 1;
        if (tmo) begin
          rsp_er = 1'b1; rsp_rd = '0;
        end else begin
          rsp_er = m_uart ? err_u : err_g;
          rsp_rd = m_write ? 32'h0 : (m_uart ? rd_u : rd_g);
        end
      end
    end
  end

  int         p;
  bit         insel, inacc;
  logic [1:0] exp_rv, exp_rdy;

  always @(negedge PCLK) begin
    p = ecount;
    if (PRESET) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_err",   bus.rsp_err, 0);
      chk("rst_psel",      {bus.PSEL_GPIO, bus.PSEL_UART, bus.PENABLE, bus.PWRITE}, 0);
      chk("rst_paddr",     bus.PADDR, 0);
      chk("rst_pwdata",    bus.PWDATA, 0);
      chk("rst_pstrb",     bus.PSTRB, 0);
    end else begin
      insel = busy && (p >= k) && (p <= k + n_acc);
      inacc = busy && (p >= k + 1) && (p <= k + n_acc);
      chk("psel_gpio", bus.PSEL_GPIO, insel && !m_uart);
      chk("psel_uart", bus.PSEL_UART, insel && m_uart);
      chk("penable",   bus.PENABLE, inacc);
      if (insel) begin
        chk("paddr",  bus.PADDR, m_addr);
        chk("pwdata", bus.PWDATA, m_wdata);
        chk("pwrite", bus.PWRITE, m_write);
        chk("pstrb",  bus.PSTRB, m_write ? m_strb : 4'b0000);
      end
      exp_rv = (p == rsp_edge) ? (rsp_own ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      if (p == rsp_edge) begin
        chk("rsp_rdata", bus.rsp_rdata, rsp_rd);
        chk("rsp_err",   bus.rsp_err, rsp_er);
      end
      exp_rdy = 2'b00;
      if (next_free <= p + 1 && bus.req_valid != 2'b00)
        exp_rdy = pick(bus.req_valid, last) ? 2'b10 : 2'b01;
      chk("req_ready", bus.req_ready, exp_rdy);
    end
  end

  task automatic do_req(input int i, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, output int acc);
    bit got;
    got = 1'b0;
    @(posedge PCLK); #1;
    bus.req_addr[i*32 +: 32]  = a;
    bus.req_wdata[i*32 +: 32] = d;
    bus.req_strb[i*4 +: 4]    = s;
    bus.req_write[i]          = wr;
    bus.req_valid[i]          = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge PCLK);
      if (bus.req_ready[i]) got = 1'b1;
      @(posedge PCLK); #1;
    end
    acc = ecount;
    bus.req_valid[i] = 1'b0;
    chk("accept_bound", got, 1);
  endtask

  task automatic wait_rsp(input int i, output int e, output logic [31:0] rd, output logic er);
    bit got;
    got = 1'b0; e = -1; rd = '0; er = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge PCLK);
      if (bus.rsp_valid[i]) begin
        got = 1'b1; e = ecount; rd = bus.rsp_rdata; er = bus.rsp_err;
      end
    end
    chk("rsp_bound", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int          acc, re, n, nrsp;
    logic [31:0] rd;
    logic        er, rerr;
    logic [1:0]  order [4];

    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb  = '0;

    repeat (2) @(posedge PCLK); #1;
    bus.req_valid = 2'b01;
    #1;
    chk("lit_rst_ready", bus.req_ready, 2'b00);
    chk("lit_rst_psel", {bus.PSEL_GPIO, bus.PSEL_UART, bus.PENABLE}, 3'b000);
    bus.req_valid = 2'b00;
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // Zero-wait GPIO write from requester 0
    do_req(0, 1'b1, 32'h001, 32'h0000_00A5, 4'b0001, acc);
    chk("lit_t1_psel_gpio", bus.PSEL_GPIO, 1);
    chk("lit_t1_pstrb", bus.PSTRB, 4'b0001);
    wait_rsp(0, re, rd, er);
    chk("lit_t1_latency", re - acc, 2);
    chk("lit_t1_err", er, 0);

    // UART read with three wait states
    wait_u = 3;
    do_req(1, 1'b0, 32'h100, 32'hFFFF_FFFF, 4'b1111, acc);
    chk("lit_t2_pstrb", bus.PSTRB, 4'b0000);
    wait_rsp(1, re, rd, er);
    chk("lit_t2_latency", re - acc, 5);
    chk("lit_t2_rdata", rd, 32'h0000_005A);
    chk("lit_t2_err", er, 0);
    wait_u = 0;

    // Decode error
    do_req(0, 1'b1, 32'h200, 32'h1111_1111, 4'b1111, acc);
    chk("lit_t3_no_psel", {bus.PSEL_GPIO, bus.PSEL_UART}, 2'b00);
    wait_rsp(0, re, rd, er);
    chk("lit_t3_latency", re - acc, 0);
    chk("lit_t3_err", er, 1);
    chk("lit_t3_rdata", rd, 0);

    // Slave error on GPIO
    err_g = 1'b1;
    do_req(1, 1'b1, 32'h010, 32'h0000_1234, 4'b1111, acc);
    wait_rsp(1, re, rd, er);
    chk("lit_t4_err", er, 1);
    err_g = 1'b0;

    // Continuous contention, four transfers
    wait_u = 1;
    @(posedge PCLK); #1;
    bus.req_addr  = {32'h0000_0104, 32'h0000_0004};
    bus.req_wdata = {32'hBEEF_0001, 32'hDEAD_0000};
    bus.req_strb  = 8'h3C;
    bus.req_write = 2'b10;
    bus.req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge PCLK);
      if (bus.req_ready != 2'b00) begin
        order[n] = bus.req_ready;
        n++;
        @(posedge PCLK); #1;
        if (n == 4) bus.req_valid = 2'b00;
        else if (order[n-1][1]) bus.req_addr[63:32] = bus.req_addr[63:32] + 32'd4;
        else                    bus.req_addr[31:0]  = bus.req_addr[31:0] + 32'd4;
      end else begin
        @(posedge PCLK); #1;
      end
    end
    chk("lit_t5_count", n, 4);
    chk("lit_t5_g0", order[0], 2'b01);
    chk("lit_t5_g1", order[1], 2'b10);
    chk("lit_t5_g2", order[2], 2'b01);
    chk("lit_t5_g3", order[3], 2'b10);
    repeat (12) @(posedge PCLK);
    wait_u = 0;

    // Reset during ACCESS
    wait_g = 1000;
    do_req(0, 1'b0, 32'h020, 32'h0, 4'b0000, acc);
    @(posedge PCLK); #1;
    chk("lit_t6_in_access", bus.PENABLE, 1);
    PRESET = 1'b1;
    #1;
    chk("lit_t6_async_clear", {bus.PSEL_GPIO, bus.PENABLE, bus.rsp_valid}, 4'b0000);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    wait_g = 0;
    bus.req_addr  = {32'h0000_0030, 32'h0000_0034};
    bus.req_write = 2'b00;
    bus.req_valid = 2'b11;
    @(negedge PCLK);
    chk("lit_t6_post_reset_grant", bus.req_ready, 2'b01);
    @(posedge PCLK); #1;
    bus.req_valid = 2'b00;
    repeat (6) @(posedge PCLK);

    // Slave that never becomes ready
    wait_u = 1000;
    do_req(1, 1'b0, 32'h1F0, 32'h0, 4'b0000, acc);
    nrsp = 0; rerr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge PCLK);
      if (bus.rsp_valid[1]) begin nrsp++; rerr = bus.rsp_err; end
    end
`ifdef APB_TIMEOUT_EN
    chk("lit_t7_timeout_rsp", nrsp, 1);
    chk("lit_t7_timeout_err", rerr, 1);
`else
    chk("lit_t7_no_rsp", nrsp, 0);
    chk("lit_t7_still_access", bus.PENABLE, 1);
`endif
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    wait_u = 0;
    repeat (3) @(posedge PCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that arbitrates round-robin between requesters and sequences APB transfers. Accepted requests become SETUP/ACCESS transfers on a shared APB bus that serves the GPIO and UART slaves. The block decodes the address into one PSEL per slave, returns read data and error status to the owning requester, and guarantees that only one transfer is in flight at a time.

## Interface
- ADDR_W, 32, address width (all buses)
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS wait cycles (only with timeout feature)
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid, held until req_ready
- req_write  in  2  per-requester direction, 1 = write
- req_addr  in  2*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  packed write data
- req_strb  in  8  packed byte strobes, 4 per requester
- req_ready  out  2  acceptance, combinational, one-hot or zero
- rsp_valid  out  2  one-cycle response pulse to owning requester
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- PADDR, PWDATA  out  ADDR_W/DATA_W  APB address/write data
- PSTRB  out  4  APB strobes
- PWRITE, PENABLE  out  1  APB controls
- PSEL_GPIO, PSEL_UART  out  1  slave selects
- PRDATA_GPIO, PRDATA_UART  in  DATA_W  slave read data
- PREADY_GPIO, PREADY_UART, PSLVERR_GPIO, PSLVERR_UART  in  1  slave ready/error

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is high, the arbiter picks the winner and raises req_ready[winner]. On that edge the block captures the winner's addr/wdata/strb/write and owner index, and updates the last-grant pointer.
- Round-robin: if both requesters are valid, the one not granted last wins. If only one is valid, it wins. The pointer resets to 1, so requester 0 wins the first contention.
- Decode: addr[ADDR_W-1:9] != 0 is a decode error. Otherwise addr[8]=0 selects GPIO and addr[8]=1 selects UART.
- Decode error: no APB cycle. The block stays in IDLE. rsp_valid[owner]=1, rsp_err=1 and rsp_rdata=0 on the next cycle.
- SETUP: selected PSEL=1, PENABLE=0. Next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1. The block samples the selected slave's PREADY.
  - PREADY high: the transfer completes. Next state is IDLE, with rsp_valid[owner]=1 the following cycle.
  - For reads, rsp_rdata is the selected PRDATA; for writes, rsp_rdata=0.
  - rsp_err is the selected PSLVERR.
  - PREADY low: the block holds ACCESS with all APB outputs stable.
- PSTRB = captured strobes for writes and is forced to 4'b0000 for reads (slaves flag nonzero read strobes as errors).
- PADDR, PWDATA, PWRITE and PSTRB are registered and held constant from SETUP through ACCESS completion.
- The unselected PSEL is always 0.

## Timing
- Reset value of every output is 0: PADDR, PWDATA, PSTRB, PWRITE, PENABLE, both PSELs, rsp_valid, rsp_rdata, rsp_err. req_ready is also 0 while PRESET is high. State is IDLE.
- Accept on edge k, SETUP in cycle k+1, ACCESS in cycle k+2.
  - With zero wait states, rsp_valid is high in cycle k+3 and the next accept can occur at edge k+3.
  - Each slave wait state adds one cycle.
- req_ready is only asserted in IDLE. A requester whose req_valid is high during SETUP/ACCESS waits, with no loss of request.
- A request deasserted before req_ready is dropped silently.
- Reset mid-transfer: all outputs clear immediately and asynchronously. No response is issued for the aborted transfer, and the pointer returns to 1.
- A response pulse and a new acceptance in the same cycle are legal and independent.

## Configuration
- APB_TIMEOUT_EN defined: a cycle counter clears on entering ACCESS and increments each ACCESS cycle with PREADY low. When it reaches TIMEOUT, the transfer aborts: PSEL/PENABLE drop, state goes to IDLE, and the next cycle gives rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0. The counter width is clog2(TIMEOUT+1).
- APB_TIMEOUT_EN undefined: there is no counter, and ACCESS waits indefinitely for PREADY.

## Structure
- Package apb_arb_pkg holds the following, shared with bus-level benches:
  - the state enum (IDLE/SETUP/ACCESS);
  - the decode constants: SLAVE_SEL_BIT=8, GPIO select value 0, UART select value 1, decode-error upper-address mask.
- Sub-module rr_arbiter2: the 2-way round-robin grant plus last-grant pointer, with inputs req[1:0] and accept and output grant[1:0].

## Test plan
- Requester 0 writes addr 0x001, wdata 0x000000A5, strb 0001 to GPIO -> PSEL_GPIO high for 2 cycles, PSTRB=0001, and rsp_valid[0] at k+3 with rsp_err=0.
- Requester 1 reads addr 0x100 from UART, with PREADY_UART low for 3 ACCESS cycles and PRDATA_UART=0x5A -> ACCESS lasts 4 cycles, PSTRB=0000, rsp_rdata=0x5A on rsp_valid[1].
- Both requesters valid continuously, 4 transfers -> grants in order 0,1,0,1, never two transfers overlapping.
- Requester 0 issues addr 0x200 -> no PSEL asserted, and rsp_valid[0] next cycle with rsp_err=1, rsp_rdata=0.
- PSLVERR_GPIO=1 at completion -> rsp_err=1. PRESET pulsed during ACCESS -> all outputs 0 at once, no rsp_valid, and a subsequent contention is granted to requester 0.
- With APB_TIMEOUT_EN, TIMEOUT=4 and PREADY held low -> abort after 4 ACCESS cycles with rsp_err=1. Without the macro -> the block remains in ACCESS.
